// File: rtl/uart_tx_arbiter.sv
// Two-port round-robin arbiter feeding a single UART transmitter.
// Captures a byte plus its parity settings, holds it in LOAD until Tx_busy answers or the timer expires.
module uart_tx_arbiter #(
   parameter int P_Data_Width = 8,
   parameter int TIMEOUT      = 16
) (
   input  logic                    Clk,
   input  logic                    Reset,
   input  logic [P_Data_Width-1:0] Req0_Data,
   input  logic                    Req0_Valid,
   output logic                    Req0_Ready,
   input  logic [P_Data_Width-1:0] Req1_Data,
   input  logic                    Req1_Valid,
   output logic                    Req1_Ready,
   input  logic                    Cfg0_Parity_EN,
   input  logic                    Cfg0_Parity_TYP,
   input  logic                    Cfg1_Parity_EN,
   input  logic                    Cfg1_Parity_TYP,
   input  logic                    Tx_busy,
   output logic [P_Data_Width-1:0] Tx_P_Data,
   output logic                    Tx_D_Valid,
   output logic                    Tx_Parity_EN,
   output logic                    Tx_Parity_TYP,
   output logic [1:0]              Grant,
   output logic                    Timeout_Err
);

   // state     | meaning
   // IDLE      | no frame owned; arbitrate and capture on any valid request
   // LOAD      | byte offered to transmitter, timer running until Tx_busy
   // WAIT_DONE | transmitter busy with the frame; wait for Tx_busy to fall
   typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE} state_t;

   localparam logic [7:0] CNT_INIT = 8'(TIMEOUT - 1);

   state_t                  state_q, state_d;
   logic [1:0]              grant_q, grant_d;
   logic [P_Data_Width-1:0] data_q, data_d;
   logic                    par_en_q, par_en_d;
   logic                    par_typ_q, par_typ_d;
   logic                    tx_valid_q, tx_valid_d;
   logic                    rdy0_q, rdy0_d;
   logic                    rdy1_q, rdy1_d;
   logic                    tmo_err_q, tmo_err_d;
   logic                    last_q, last_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    win1;

   // last_q = 1 means port 1 was served last, so port 0 takes the next tie
   assign win1 = Req1_Valid & (~Req0_Valid | ~last_q);

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      tx_valid_d = tx_valid_q;
      rdy0_d     = 1'b0;
      rdy1_d     = 1'b0;
      tmo_err_d  = 1'b0;
      last_d     = last_q;
      cnt_d      = cnt_q;
      case (state_q)
         IDLE: begin
            if (Req0_Valid | Req1_Valid) begin
               state_d    = LOAD;
               grant_d    = win1 ? 2'b10 : 2'b01;
               data_d     = win1 ? Req1_Data : Req0_Data;
               par_en_d   = win1 ? Cfg1_Parity_EN : Cfg0_Parity_EN;
               par_typ_d  = win1 ? Cfg1_Parity_TYP : Cfg0_Parity_TYP;
               tx_valid_d = 1'b1;
               rdy0_d     = ~win1;
               rdy1_d     = win1;
               last_d     = win1;
               cnt_d      = CNT_INIT;
            end
         end
         LOAD: begin
            if (Tx_busy) begin
               state_d    = WAIT_DONE;
               tx_valid_d = 1'b0;
            end else if (cnt_q == 8'd0) begin
               state_d    = IDLE;
               tx_valid_d = 1'b0;
               grant_d    = 2'b00;
               tmo_err_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         WAIT_DONE: begin
            if (!Tx_busy) begin
               state_d = IDLE;
               grant_d = 2'b00;
            end
         end
         default: begin
            state_d    = IDLE;
            grant_d    = 2'b00;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= IDLE;
         grant_q    <= 2'b00;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         tx_valid_q <= 1'b0;
         rdy0_q     <= 1'b0;
         rdy1_q     <= 1'b0;
         tmo_err_q  <= 1'b0;
         last_q     <= 1'b1;
         cnt_q      <= 8'd0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         tx_valid_q <= tx_valid_d;
         rdy0_q     <= rdy0_d;
         rdy1_q     <= rdy1_d;
         tmo_err_q  <= tmo_err_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
      end
   end

   assign Req0_Ready    = rdy0_q;
   assign Req1_Ready    = rdy1_q;
   assign Tx_P_Data     = data_q;
   assign Tx_D_Valid    = tx_valid_q;
   assign Tx_Parity_EN  = par_en_q;
   assign Tx_Parity_TYP = par_typ_q;
   assign Grant         = grant_q;
   assign Timeout_Err   = tmo_err_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter P_Data_Width, default 8, byte width of every data path.
REQ-002 Parameter TIMEOUT, default 16, max cycles in LOAD waiting for Tx_busy before the frame is dropped; legal range 2..255.
REQ-003 Clk  in  1  single clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 Req0_Data  in  P_Data_Width  byte offered by requester 0.
REQ-006 Req0_Valid  in  1  requester 0 has a byte; held with Req0_Data stable until Req0_Ready seen.
REQ-007 Req0_Ready  out  1  one-cycle acceptance pulse to requester 0.
REQ-008 Req1_Data / Req1_Valid / Req1_Ready  in/in/out  P_Data_Width/1/1  same as REQ-005..007 for requester 1.
REQ-009 Cfg0_Parity_EN, Cfg0_Parity_TYP  in  1 each  parity settings for requester 0 frames.
REQ-010 Cfg1_Parity_EN, Cfg1_Parity_TYP  in  1 each  parity settings for requester 1 frames.
REQ-011 Tx_busy  in  1  busy flag from the UART transmitter.
REQ-012 Tx_P_Data  out  P_Data_Width  byte presented to the transmitter.
REQ-013 Tx_D_Valid  out  1  data-valid to the transmitter.
REQ-014 Tx_Parity_EN, Tx_Parity_TYP  out  1 each  parity settings to the transmitter.
REQ-015 Grant  out  2  one-hot owner of the current frame; 2'b00 when none.
REQ-016 Timeout_Err  out  1  one-cycle pulse when a frame is dropped by timeout.

Function
REQ-017 FSM states SHALL be IDLE, LOAD, WAIT_DONE; all outputs registered.
REQ-018 IDLE: if any ReqN_Valid=1 at an edge, SHALL capture the granted port's data and Cfg bits, set Grant, go to LOAD; else stay.
REQ-019 Arbitration SHALL be round-robin: single valid wins; both valid -> the port not served last wins; last-served pointer resets to 1 (port 0 wins first tie).
REQ-020 ReqN_Ready SHALL be 1 for exactly the cycle after capture (first LOAD cycle), only for the granted port.
REQ-021 LOAD: Tx_D_Valid=1, Tx_P_Data=captured byte; on Tx_busy=1 sampled -> WAIT_DONE with Tx_D_Valid=0 from next cycle.
REQ-022 LOAD: if Tx_busy not sampled high within TIMEOUT cycles -> Timeout_Err pulse 1 cycle, Tx_D_Valid=0, Grant=00, IDLE; byte discarded, pointer still updated.
REQ-023 WAIT_DONE: on Tx_busy=0 sampled -> IDLE, Grant=00; at least one IDLE cycle between frames.
REQ-024 Tx_Parity_EN/TYP SHALL hold captured values from capture until next capture, unchanged during a frame even if Cfg inputs change.
REQ-025 Tx_P_Data SHALL hold the last captured byte outside LOAD.
REQ-026 Valid changes outside IDLE SHALL be ignored; no capture, no Ready.
REQ-027 Valid dropped before Ready (protocol violation) after capture: frame still sent.

Reset
REQ-028 Reset=1 at an edge SHALL force IDLE, Tx_D_Valid=0, Tx_P_Data=0, Tx_Parity_EN=0, Tx_Parity_TYP=0, Grant=00, Req0_Ready=Req1_Ready=0, Timeout_Err=0, pointer=1, timeout counter=0.
REQ-029 Reset mid-frame SHALL abort it with no Ready or Timeout_Err pulse; Reset dominates all other inputs.

Verification
REQ-030 Req0_Valid=1, Data=8'hA5, Cfg0=(1,1); Tx_busy rises 2 cycles after Tx_D_Valid, low 10 cycles later -> Grant=01, Req0_Ready 1 cycle, Tx_P_Data=A5, Tx_Parity_EN=1/TYP=1, Tx_D_Valid drops cycle after busy seen, IDLE after busy falls.
REQ-031 Req0 and Req1 valid together, data 8'h11/8'h22 -> 8'h11 sent first, then 8'h22; Req1_Ready only after first frame's busy falls.
REQ-032 Req0 valid continuously with Req1 valid -> grants alternate 01,10,01,10 over four frames.
REQ-033 Tx_busy held 0, TIMEOUT=16 -> Timeout_Err single pulse 16 cycles after LOAD entry, Grant=00, next request accepted normally.
REQ-034 Reset asserted in WAIT_DONE -> next cycle all outputs at REQ-028 values; subsequent tie grants port 0.
REQ-035 Cfg0_Parity_EN toggled during WAIT_DONE -> Tx_Parity_EN unchanged until next capture.
